// File: rtl/ifu.sv
// ifu: instruction fetch stage that keeps one instruction in flight between imem and decode
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   imem_req_*         read request to instruction memory (addr = current pc)
//   imem_resp_*        read response carrying the instruction word
//   if_to_id_*         {pc, inst} handed to decode
//   id_to_if_*         next pc (dnpc) returned by decode
//   if_fault           sticky flag raised when decode returns a misaligned pc
//   fetch_cnt          instructions handed to decode, wraps modulo 2^32
module ifu #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [DATA_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_resp_valid,
    output logic                    imem_resp_ready,
    input  logic [DATA_WIDTH-1:0]   imem_resp_data,
    output logic [2*DATA_WIDTH-1:0] if_to_id_bus,
    output logic                    if_to_id_valid,
    input  logic                    id_to_if_ready,
    input  logic [DATA_WIDTH-1:0]   id_to_if_bus,
    input  logic                    id_to_if_valid,
    output logic                    if_to_id_ready,
    output logic                    if_fault,
    output logic [31:0]             fetch_cnt
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, NPC, FAULT} state_t;
    state_t state, state_nxt;
    logic [DATA_WIDTH-1:0] pc, inst;
    always_comb begin
        state_nxt       = state;
        imem_req_valid  = (state == REQ);
        imem_resp_ready = (state == WAIT);
        if_to_id_valid  = (state == SEND);
        if_to_id_ready  = (state == NPC);
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     state_nxt = imem_req_ready ? WAIT : REQ;
            WAIT:    state_nxt = imem_resp_valid ? SEND : WAIT;
            SEND:    state_nxt = id_to_if_ready ? NPC : SEND;
            NPC:     state_nxt = !id_to_if_valid ? NPC : (|id_to_if_bus[1:0] ? FAULT : REQ);
            default: state_nxt = FAULT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            inst      <= '0;
            fetch_cnt <= '0;
            if_fault  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == WAIT && imem_resp_valid)
                inst <= imem_resp_data;
            if (state == SEND && id_to_if_ready)
                fetch_cnt <= fetch_cnt + 32'd1;
            // A misaligned dnpc is still recorded as pc so the faulting address is observable.
            if (state == NPC && id_to_if_valid) begin
                pc       <= id_to_if_bus;
                if_fault <= |id_to_if_bus[1:0];
            end
        end
    end
    assign imem_req_addr = pc;
    assign if_to_id_bus  = {pc, inst};
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for the ifu fetch stage with modelled memory and decode
module tb_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid, imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic [63:0] if_to_id_bus;
    logic        if_to_id_valid, id_to_if_ready;
    logic [31:0] id_to_if_bus;
    logic        id_to_if_valid, if_to_id_ready;
    logic        if_fault;
    logic [31:0] fetch_cnt;
    int          checks, failures, cyc;
    logic [31:0] cnt_exp;
    logic [63:0] sb[$];

    ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready), .imem_resp_data(imem_resp_data),
        .if_to_id_bus(if_to_id_bus), .if_to_id_valid(if_to_id_valid), .id_to_if_ready(id_to_if_ready),
        .id_to_if_bus(id_to_if_bus), .id_to_if_valid(id_to_if_valid), .if_to_id_ready(if_to_id_ready),
        .if_fault(if_fault), .fetch_cnt(fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req_valid && n < 50) begin
            step();
            n++;
        end
        check("req_timeout", 64'(n < 50), 64'd1);
    endtask

    // One full instruction with stalls on each handshake; junk drives a stray response during REQ.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] ins, input logic [31:0] dnpc,
                             input int rs, input int rd, input int is, input int nd, input bit junk);
        int t0;
        logic [63:0] exp;
        wait_req();
        t0 = cyc;
        check("req_addr", imem_req_addr, addr);
        check("req_resp_ready", imem_resp_ready, 0);
        for (int i = 0; i < rs; i++) begin
            imem_req_ready  = 1'b0;
            imem_resp_valid = junk;
            imem_resp_data  = 32'hdead_beef;
            step();
            check("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, addr});
        end
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_ready", {imem_resp_ready, imem_req_valid}, 2'b10);
        for (int i = 0; i < rd; i++) begin
            step();
            check("wait_hold", {imem_resp_ready, if_to_id_valid}, 2'b10);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = ins;
        sb.push_back({addr, ins});
        step();
        imem_resp_valid = 1'b0;
        check("send_valid", {if_to_id_valid, imem_resp_ready}, 2'b10);
        for (int i = 0; i < is; i++) begin
            id_to_if_ready = 1'b0;
            step();
            check("send_hold", {if_to_id_valid, if_to_id_bus}, {1'b1, sb[0]});
        end
        id_to_if_ready = 1'b1;
        exp = sb.pop_front();
        check("handoff_bus", if_to_id_bus, exp);
        step();
        id_to_if_ready = 1'b0;
        cnt_exp++;
        check("fetch_cnt", fetch_cnt, cnt_exp);
        check("npc_ready", {if_to_id_ready, if_to_id_valid}, 2'b10);
        for (int i = 0; i < nd; i++) begin
            step();
            check("npc_hold", {if_to_id_ready, imem_req_valid}, 2'b10);
        end
        id_to_if_valid = 1'b1;
        id_to_if_bus   = dnpc;
        step();
        id_to_if_valid = 1'b0;
        check("cycles", cyc - t0, 4 + rs + rd + is + nd);
        if (dnpc[1:0] == 2'b00)
            check("next_req", {imem_req_valid, imem_req_addr}, {1'b1, dnpc});
        else
            check("fault_set", {if_fault, imem_req_valid, imem_req_addr}, {2'b10, dnpc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; cnt_exp = 0;
        rst = 1'b1;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        id_to_if_ready = 0; id_to_if_bus = 0; id_to_if_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hs", {imem_req_valid, imem_resp_ready, if_to_id_valid, if_to_id_ready}, 0);
            check("rst_cnt", {if_fault, fetch_cnt}, 0);
        end
        rst = 1'b0;
        #1;
        check("idle_req", imem_req_valid, 0);
        check("idle_bus", {if_to_id_bus, imem_req_addr}, {RST_PC, 32'h0, RST_PC});
        step();
        check("first_req", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC});
        fetch_one(RST_PC, 32'h0010_0093, 32'h8000_0004, 0, 0, 0, 0, 0);
        fetch_one(32'h8000_0004, 32'h0020_0113, 32'h8000_0008, 3, 5, 2, 4, 0);
        fetch_one(32'h8000_0008, 32'h0030_0193, 32'h8000_0100, 2, 1, 0, 0, 1);
        fetch_one(32'h8000_0100, 32'h0040_0213, 32'h8000_0102, 0, 0, 0, 0, 0);
        imem_req_ready = 1; imem_resp_valid = 1; id_to_if_ready = 1; id_to_if_valid = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("fault_quiet", {imem_req_valid, if_to_id_valid, imem_resp_ready, if_to_id_ready, if_fault}, 5'b00001);
        end
        imem_req_ready = 0; imem_resp_valid = 0; id_to_if_ready = 0; id_to_if_valid = 0;
        rst = 1'b1;
        #1;
        check("fault_clear", {if_fault, imem_req_addr, fetch_cnt}, {1'b0, RST_PC, 32'h0});
        step();
        step();
        rst = 1'b0;
        cnt_exp = 0;
        fetch_one(RST_PC, 32'h0050_0293, 32'h8000_0010, 1, 0, 1, 0, 0);
        wait_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("mid_wait", imem_resp_ready, 1);
        #2 rst = 1'b1;
        #1;
        check("async_hs", {imem_req_valid, imem_resp_ready, if_to_id_valid, if_to_id_ready}, 0);
        check("async_regs", {if_to_id_bus, imem_req_addr, fetch_cnt}, {RST_PC, 32'h0, RST_PC, 32'h0});
        step();
        step();
        rst = 1'b0;
        cnt_exp = 0;
        fetch_one(RST_PC, 32'h0060_0313, 32'h8000_0004, 0, 2, 0, 1, 0);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch stage of the multi-cycle NPC core, directly upstream of the decode stage. Holds the architectural PC and issues one instruction-memory read per instruction. Delivers `{pc, inst}` to decode over a valid/ready handshake, then waits for decode to return the next PC before fetching again. Non-speculative: exactly one instruction is in flight between fetch and decode.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of PC, instruction and memory data.
- `RESET_PC`, default 32'h8000_0000: PC value loaded at reset.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req_valid` out 1: read request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out DATA_WIDTH: read address, equal to the current PC.
- `imem_resp_valid` in 1: read data valid.
- `imem_resp_ready` out 1: fetch accepts the response.
- `imem_resp_data` in DATA_WIDTH: instruction word.
- `if_to_id_bus` out 2*DATA_WIDTH: `{pc, inst}`, with pc in the upper half.
- `if_to_id_valid` out 1: bus valid to decode.
- `id_to_if_ready` in 1: decode accepts the bus.
- `id_to_if_bus` in DATA_WIDTH: next PC (dnpc) from decode.
- `id_to_if_valid` in 1: dnpc valid.
- `if_to_id_ready` out 1: fetch accepts dnpc.
- `if_fault` out 1: sticky misaligned-PC fault.
- `fetch_cnt` out 32: number of instructions handed to decode; wraps modulo 2^32.

## Operation
- FSM states: IDLE, REQ, WAIT, SEND, NPC, FAULT.
- IDLE: entered on reset. Moves to REQ on the first clock edge after `rst` deasserts.
- REQ: `imem_req_valid`=1 with `imem_req_addr`=pc. When `imem_req_ready`=1, moves to WAIT.
- WAIT: `imem_resp_ready`=1. When `imem_resp_valid`=1, latches `imem_resp_data` into inst and moves to SEND.
  - Responses arriving in any other state are ignored. Memory shares `rst`, so no stale responses exist after reset.
- SEND: `if_to_id_valid`=1 and `if_to_id_bus`={pc, inst}, held stable. When `id_to_if_ready`=1, increments `fetch_cnt` and moves to NPC.
- NPC: `if_to_id_ready`=1. When `id_to_if_valid`=1:
  - If `id_to_if_bus[1:0]`==0: pc <= `id_to_if_bus`, move to REQ.
  - Otherwise: pc <= `id_to_if_bus`, `if_fault` <= 1, move to FAULT.
- FAULT: terminal state. All valid/ready outputs are 0 and no requests are issued. Exit only through reset.
- In each state, every valid/ready output not named for that state is 0.
- Handshakes complete only when valid and ready are both high in the same cycle. Valid never depends combinationally on ready.
- `imem_req_addr` and `if_to_id_bus` are driven from registers. The address is held constant while in REQ, whether or not `imem_req_ready` is asserted.

## Timing
- Reset values while `rst`=1 and in the IDLE cycle:
  - pc=RESET_PC, inst=0, `fetch_cnt`=0, `if_fault`=0.
  - All valid/ready outputs are 0.
  - `if_to_id_bus`={RESET_PC, 0}, `imem_req_addr`=RESET_PC.
- Reset asserted mid-operation clears state immediately (asynchronously), in any state including FAULT.
- Minimum cycle cost per instruction is 4: REQ, WAIT, SEND and NPC each take 1 cycle when the handshake partner is ready. Each stall adds exactly its stall cycles.
- `if_to_id_valid` rises 1 cycle after the response handshake.
- `imem_req_valid` rises 1 cycle after the dnpc handshake.
- `fetch_cnt` updates on the edge that completes the SEND handshake.
- `if_fault` is set on the edge that completes the NPC handshake.

## Test plan
1. Reset: hold `rst`=1 for 3 cycles, then release.
   - During reset all valids/readies are 0 and `fetch_cnt`=0.
   - Cycle 1 after release: `imem_req_valid`=0.
   - Cycle 2: `imem_req_valid`=1, `imem_req_addr`=0x8000_0000.
2. Zero-wait fetch: memory always ready and answers 0x00100093 one cycle after the request; decode always ready and returns dnpc 0x8000_0004.
   - `if_to_id_bus`={0x8000_0000, 0x00100093}.
   - Next request address is 0x8000_0004, issued 4 cycles after the first.
   - `fetch_cnt`=1.
3. Backpressure: `imem_req_ready` low 3 cycles, response delayed 5 cycles, `id_to_if_ready` low 2 cycles, `id_to_if_valid` late 4 cycles.
   - Address and bus stay stable throughout.
   - Exactly one handoff occurs and `fetch_cnt` increments by 1.
   - Total cost is 4+14 cycles.
4. Redirect: dnpc=0x8000_0100 → next `imem_req_addr`=0x8000_0100; a response injected outside WAIT is ignored.
5. Misaligned dnpc=0x8000_0102 → `if_fault`=1 on the next cycle. Afterwards `imem_req_valid` and `if_to_id_valid` remain 0 for 20 cycles, and pulsing `rst` clears the fault.
6. Reset mid-WAIT: assert `rst` while in WAIT → outputs return to reset values asynchronously; after release the fetch restarts at 0x8000_0000 with `fetch_cnt`=0.
